// File: rtl/hazard_sb_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit and its MDU scoreboard.
package hazard_pkg;

  localparam int NREGS_DEF = 32;
  localparam int REG_W_DEF = $clog2(NREGS_DEF);

  typedef logic [REG_W_DEF-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // M is the younger producer, so it wins over W when both match.
  function automatic fwd_sel_t fwd_select(input logic hit_m, input logic hit_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (hit_m) begin
      sel = FWD_M;
    end else if (hit_w) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_sb_unit_mdu_scoreboard.sv
// Tracks the single in-flight MDU op: destination busy bits, latency countdown
// and the write-back slot it shares with the W stage.
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int REG_W   = $clog2(NREGS),
  parameter int MDU_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mdu_start,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             reg_write_w,
  output logic [NREGS-1:0] busy,
  output logic             cnt_gt1,
  output logic             mdu_busy,
  output logic             mdu_wb_valid,
  output logic [REG_W-1:0] mdu_wb_rd
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LAT = CW'(MDU_LAT);

  logic [CW-1:0]    cnt;
  logic [REG_W-1:0] mdu_rd;
  logic [NREGS-1:0] busy_next;

  // The register file has one write port and W owns it, so a finished MDU
  // result only takes the port in a cycle where W is not writing.
  assign mdu_wb_valid = (cnt == CW'(1)) && !reg_write_w;
  assign mdu_wb_rd    = mdu_rd;
  assign mdu_busy     = (cnt != '0);
  assign cnt_gt1      = (cnt > CW'(1));

  // Next busy vector: clear the completing destination, then mark a new issue.
  always_comb begin
    busy_next = busy;
    if (mdu_wb_valid) begin
      busy_next[mdu_rd] = 1'b0;
    end
    if (mdu_start && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Countdown from issue; stays at 1 while a W write blocks the write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mdu_rd <= '0;
      busy   <= '0;
    end else begin
      busy <= busy_next;
      if (mdu_start) begin
        cnt    <= LAT;
        mdu_rd <= issue_rd;
      end else if (mdu_wb_valid) begin
        cnt <= '0;
      end else if (cnt > CW'(1)) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Only one op may be in flight; the D-stage structural stall keeps this true.
  a_single_issue: assert property (@(posedge clk) disable iff (rst)
    !(mdu_start && (cnt != '0) && !mdu_wb_valid));

endmodule

// File: rtl/hazard_sb_unit.sv
// Hazard unit for the 5-stage pipeline: E-stage forwarding, load-use and
// scoreboard stalls, branch flush, and a saturating stall-cycle counter.
module hazard_sb_unit
  import hazard_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int REG_W   = $clog2(NREGS),
  parameter int MDU_LAT = 4,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_d,
  input  logic             reg_write_d,
  input  logic             mdu_op_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic             reg_write_e,
  input  logic [1:0]       result_src_e,
  input  logic             mdu_start_e,
  input  logic             pcsrc_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_w,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             mdu_busy,
  output logic             mdu_wb_valid,
  output logic [REG_W-1:0] mdu_wb_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [NREGS-1:0] busy;
  logic             cnt_gt1;
  logic             lw_stall;
  logic             sb_stall;
  logic             st_stall;
  logic             raw_stall;
  logic             stall_any;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;

  mdu_scoreboard #(
    .NREGS  (NREGS),
    .REG_W  (REG_W),
    .MDU_LAT(MDU_LAT)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .mdu_start   (mdu_start_e),
    .issue_rd    (rd_e),
    .reg_write_w (reg_write_w),
    .busy        (busy),
    .cnt_gt1     (cnt_gt1),
    .mdu_busy    (mdu_busy),
    .mdu_wb_valid(mdu_wb_valid),
    .mdu_wb_rd   (mdu_wb_rd)
  );

  // Operand forwarding into E; x0 never forwards and reset forces the RF path.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if ((FWD_EN != 0) && !rst) begin
      fwd_a = fwd_select(reg_write_m && (rd_m == rs1_e) && (rs1_e != '0),
                         reg_write_w && (rd_w == rs1_e) && (rs1_e != '0));
      fwd_b = fwd_select(reg_write_m && (rd_m == rs2_e) && (rs2_e != '0),
                         reg_write_w && (rd_w == rs2_e) && (rs2_e != '0));
    end
  end

  assign forward_ae = fwd_a;
  assign forward_be = fwd_b;

  // Individual stall causes; a D source only counts when it is not x0.
  always_comb begin
    lw_stall = (result_src_e == RESULT_SRC_LOAD) && (rd_e != '0) &&
               (((rs1_d != '0) && (rs1_d == rd_e)) || ((rs2_d != '0) && (rs2_d == rd_e)));

    sb_stall = ((rs1_d != '0) && busy[rs1_d]) ||
               ((rs2_d != '0) && busy[rs2_d]) ||
               (reg_write_d && busy[rd_d]) ||
               (mdu_start_e && (rd_e != '0) &&
                (((rs1_d != '0) && (rs1_d == rd_e)) || ((rs2_d != '0) && (rs2_d == rd_e))));

    st_stall = mdu_op_d && (mdu_start_e || cnt_gt1);

    raw_stall = 1'b0;
    if (FWD_EN == 0) begin
      raw_stall = ((rs1_d != '0) &&
                   ((reg_write_e && (rs1_d == rd_e)) ||
                    (reg_write_m && (rs1_d == rd_m)) ||
                    (reg_write_w && (rs1_d == rd_w)))) ||
                  ((rs2_d != '0) &&
                   ((reg_write_e && (rs2_d == rd_e)) ||
                    (reg_write_m && (rs2_d == rd_m)) ||
                    (reg_write_w && (rs2_d == rd_w))));
    end
  end

  // A taken branch makes the D instruction wrong-path, so it beats any stall.
  always_comb begin
    stall_any = (lw_stall || sb_stall || st_stall || raw_stall) && !pcsrc_e && !rst;
    stall_f   = stall_any;
    stall_d   = stall_any;
    flush_d   = pcsrc_e && !rst;
    flush_e   = (pcsrc_e && !rst) || stall_any;
  end

  // Saturating count of stalled D cycles for performance monitoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_any && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_sb_unit.sv
// Scoreboard bench for hazard_sb_unit: directed vectors push expected
// snapshots; a negedge monitor pops and compares them and the MDU write-backs.
module tb_hazard_sb_unit;

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       reg_write_d, mdu_op_d;
    logic [4:0] rs1_e, rs2_e, rd_e;
    logic       reg_write_e;
    logic [1:0] result_src_e;
    logic       mdu_start_e, pcsrc_e;
    logic [4:0] rd_m;
    logic       reg_write_m;
    logic [4:0] rd_w;
    logic       reg_write_w;
  } stim_t;

  typedef struct packed {
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [1:0]  fa, fb;
    logic        mdu_busy, wb_valid;
    logic [4:0]  wb_rd;
    logic [15:0] stall_cnt;
    logic        stall_d2;
    logic [1:0]  fa2, fb2;
  } out_t;

  typedef struct {
    string name;
    int    cyc;
    out_t  val;
    out_t  mask;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [4:0] rd;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0;
  logic [4:0] rd_m = '0, rd_w = '0;
  logic reg_write_d = 0, mdu_op_d = 0, reg_write_e = 0, mdu_start_e = 0, pcsrc_e = 0;
  logic reg_write_m = 0, reg_write_w = 0;
  logic [1:0] result_src_e = '0;

  logic        stall_f, stall_d, flush_d, flush_e, mdu_busy, mdu_wb_valid;
  logic [1:0]  forward_ae, forward_be;
  logic [4:0]  mdu_wb_rd;
  logic [15:0] stall_cnt;
  logic        stall_f2, stall_d2, flush_d2, flush_e2, mdu_busy2, mdu_wb_valid2;
  logic [1:0]  forward_ae2, forward_be2;
  logic [4:0]  mdu_wb_rd2;
  logic [15:0] stall_cnt2;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  exp_t    expq[$];
  wb_exp_t wbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hazard_sb_unit #(.NREGS(32), .MDU_LAT(4), .FWD_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .mdu_op_d(mdu_op_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mdu_start_e(mdu_start_e), .pcsrc_e(pcsrc_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .forward_ae(forward_ae), .forward_be(forward_be),
    .mdu_busy(mdu_busy), .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd(mdu_wb_rd),
    .stall_cnt(stall_cnt)
  );

  hazard_sb_unit #(.NREGS(32), .MDU_LAT(4), .FWD_EN(0), .CNT_W(16)) dut_nofwd (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .mdu_op_d(mdu_op_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .mdu_start_e(mdu_start_e), .pcsrc_e(pcsrc_e), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .stall_f(stall_f2), .stall_d(stall_d2),
    .flush_d(flush_d2), .flush_e(flush_e2), .forward_ae(forward_ae2), .forward_be(forward_be2),
    .mdu_busy(mdu_busy2), .mdu_wb_valid(mdu_wb_valid2), .mdu_wb_rd(mdu_wb_rd2),
    .stall_cnt(stall_cnt2)
  );

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input stim_t s, input logic r);
    @(posedge clk);
    #1;
    rst          = r;
    rs1_d        = s.rs1_d;
    rs2_d        = s.rs2_d;
    rd_d         = s.rd_d;
    reg_write_d  = s.reg_write_d;
    mdu_op_d     = s.mdu_op_d;
    rs1_e        = s.rs1_e;
    rs2_e        = s.rs2_e;
    rd_e         = s.rd_e;
    reg_write_e  = s.reg_write_e;
    result_src_e = s.result_src_e;
    mdu_start_e  = s.mdu_start_e;
    pcsrc_e      = s.pcsrc_e;
    rd_m         = s.rd_m;
    reg_write_m  = s.reg_write_m;
    rd_w         = s.rd_w;
    reg_write_w  = s.reg_write_w;
  endtask

  // Queue an expected snapshot for the current cycle.
  task automatic checkOutput(input string nm, input out_t v, input out_t m);
    exp_t e;
    e.name = nm;
    e.cyc  = cyc;
    e.val  = v;
    e.mask = m;
    expq.push_back(e);
  endtask

  task automatic expCtrl(input string nm, input logic st, input logic fd, input logic fe);
    out_t v, m;
    v = '0; m = '0;
    v.stall_f = st; v.stall_d = st; v.flush_d = fd; v.flush_e = fe;
    m.stall_f = 1;  m.stall_d = 1;  m.flush_d = 1;  m.flush_e = 1;
    checkOutput(nm, v, m);
  endtask

  task automatic expFwd(input string nm, input logic [1:0] a, input logic [1:0] b);
    out_t v, m;
    v = '0; m = '0;
    v.fa = a; v.fb = b; m.fa = '1; m.fb = '1;
    checkOutput(nm, v, m);
  endtask

  task automatic expMdu(input string nm, input logic bz, input logic wv, input logic [4:0] rd);
    out_t v, m;
    v = '0; m = '0;
    v.mdu_busy = bz; v.wb_valid = wv; m.mdu_busy = 1; m.wb_valid = 1;
    if (wv) begin
      v.wb_rd = rd; m.wb_rd = '1;
    end
    checkOutput(nm, v, m);
  endtask

  task automatic expCnt(input string nm, input logic [15:0] c);
    out_t v, m;
    v = '0; m = '0;
    v.stall_cnt = c; m.stall_cnt = '1;
    checkOutput(nm, v, m);
  endtask

  task automatic expNoFwd(input string nm, input logic st, input logic [1:0] a, input logic [1:0] b);
    out_t v, m;
    v = '0; m = '0;
    v.stall_d2 = st; v.fa2 = a; v.fb2 = b;
    m.stall_d2 = 1;  m.fa2 = '1; m.fb2 = '1;
    checkOutput(nm, v, m);
  endtask

  task automatic expWb(input logic [4:0] rd, input int at);
    wb_exp_t w;
    w.cyc = at;
    w.rd  = rd;
    wbq.push_back(w);
  endtask

  // Monitor: compare queued snapshots and every MDU write-back pulse.
  out_t    act;
  exp_t    e_m;
  wb_exp_t w_m;
  always @(negedge clk) begin
    act = {stall_f, stall_d, flush_d, flush_e, forward_ae, forward_be, mdu_busy,
           mdu_wb_valid, mdu_wb_rd, stall_cnt, stall_d2, forward_ae2, forward_be2};
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      e_m = expq.pop_front();
      n_total++;
      if (e_m.cyc != cyc) begin
        $display("[TB] FAIL %s: not sampled in cycle %0d (now %0d)", e_m.name, e_m.cyc, cyc);
      end else if ((act & e_m.mask) !== (e_m.val & e_m.mask)) begin
        $display("[TB] FAIL %s: got %h, expected %h (mask %h)", e_m.name,
                 act & e_m.mask, e_m.val & e_m.mask, e_m.mask);
      end else begin
        n_pass++;
      end
    end
    while (wbq.size() > 0 && wbq[0].cyc < cyc) begin
      w_m = wbq.pop_front();
      n_total++;
      $display("[TB] FAIL wb_missing: no write-back of x%0d in cycle %0d, got none", w_m.rd, w_m.cyc);
    end
    if (mdu_wb_valid === 1'b1) begin
      n_total++;
      if (wbq.size() > 0 && wbq[0].cyc == cyc) begin
        w_m = wbq.pop_front();
        if (mdu_wb_rd === w_m.rd) begin
          n_pass++;
        end else begin
          $display("[TB] FAIL wb_rd: got x%0d, expected x%0d", mdu_wb_rd, w_m.rd);
        end
      end else begin
        $display("[TB] FAIL wb_unexpected: got pulse rd x%0d in cycle %0d, expected none", mdu_wb_rd, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    int a, b;
    out_t zero_v, all_m;
    zero_v = '0;
    all_m  = '1;

    // Reset held with hazards present: every output must be zero.
    s = '0;
    s.pcsrc_e = 1; s.result_src_e = 2'b01; s.rd_e = 7; s.rs2_d = 7;
    s.reg_write_m = 1; s.rd_m = 5; s.rs1_e = 5;
    applyStimulus(s, 1'b1);
    checkOutput("reset_outputs", zero_v, all_m);

    s = '0;
    applyStimulus(s, 1'b0);
    checkOutput("idle_after_reset", zero_v, all_m);

    // Forwarding priority.
    s = '0;
    s.rd_m = 5; s.rd_w = 5; s.rs1_e = 5; s.rs2_e = 5; s.reg_write_m = 1; s.reg_write_w = 1;
    applyStimulus(s, 1'b0);
    expFwd("fwd_m_priority", 2'b10, 2'b10);
    expCtrl("fwd_no_stall", 0, 0, 0);
    s.reg_write_m = 0;
    applyStimulus(s, 1'b0);
    expFwd("fwd_w_only", 2'b01, 2'b01);
    s.rs2_e = 6; s.rd_m = 6; s.reg_write_m = 1;
    applyStimulus(s, 1'b0);
    expFwd("fwd_mixed", 2'b01, 2'b10);
    s = '0;
    s.reg_write_m = 1; s.reg_write_w = 1;
    applyStimulus(s, 1'b0);
    expFwd("fwd_x0", 2'b00, 2'b00);

    // Load-use stall for one cycle.
    s = '0;
    s.result_src_e = 2'b01; s.rd_e = 7; s.reg_write_e = 1; s.rs2_d = 7; s.rs1_d = 3;
    applyStimulus(s, 1'b0);
    expCtrl("load_use", 1, 0, 1);
    expCnt("cnt_before_load", 16'd0);
    s = '0;
    applyStimulus(s, 1'b0);
    expCtrl("load_use_released", 0, 0, 0);
    expCnt("cnt_after_load", 16'd1);
    s.result_src_e = 2'b01;
    applyStimulus(s, 1'b0);
    expCtrl("load_rd_x0", 0, 0, 0);
    s.result_src_e = 2'b10; s.rd_e = 7; s.reg_write_e = 1; s.rs1_d = 7;
    applyStimulus(s, 1'b0);
    expCtrl("nonload_no_stall", 0, 0, 0);

    // MDU RAW: issue x9 with a dependent instruction held in D.
    s = '0;
    s.mdu_start_e = 1; s.rd_e = 9; s.rs1_d = 9;
    applyStimulus(s, 1'b0);
    a = cyc;
    expCtrl("mdu_raw_issue", 1, 0, 1);
    expMdu("mdu_issue_idle", 0, 0, 5'd0);
    expWb(5'd9, a + 4);
    s = '0;
    s.rs1_d = 9;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(s, 1'b0);
      expCtrl($sformatf("mdu_raw_hold%0d", i), 1, 0, 1);
      expMdu($sformatf("mdu_raw_busy%0d", i), 1, (i == 4), 5'd9);
    end
    applyStimulus(s, 1'b0);
    expCtrl("mdu_raw_done", 0, 0, 0);
    expMdu("mdu_raw_idle", 0, 0, 5'd0);
    expCnt("cnt_after_mdu_raw", 16'd6);

    // W collision delays the write-back by one cycle.
    s = '0;
    s.mdu_start_e = 1; s.rd_e = 12;
    applyStimulus(s, 1'b0);
    b = cyc;
    expCtrl("mdu2_issue_nodep", 0, 0, 0);
    expWb(5'd12, b + 5);
    s = '0;
    s.mdu_op_d = 1;
    applyStimulus(s, 1'b0);
    expCtrl("structural_stall", 1, 0, 1);
    s = '0;
    applyStimulus(s, 1'b0);
    expMdu("mdu2_busy", 1, 0, 5'd0);
    s.rd_d = 12; s.reg_write_d = 1;
    applyStimulus(s, 1'b0);
    expCtrl("waw_stall", 1, 0, 1);
    s = '0;
    s.reg_write_w = 1; s.rd_w = 3;
    applyStimulus(s, 1'b0);
    expMdu("wb_blocked_by_w", 1, 0, 5'd0);
    s = '0;
    applyStimulus(s, 1'b0);
    expMdu("wb_after_collision", 1, 1, 5'd12);
    applyStimulus(s, 1'b0);
    expMdu("mdu2_idle", 0, 0, 5'd0);
    expCnt("cnt_after_collision", 16'd8);

    // Taken branch overrides a load-use stall.
    s = '0;
    s.result_src_e = 2'b01; s.rd_e = 7; s.rs2_d = 7; s.pcsrc_e = 1;
    applyStimulus(s, 1'b0);
    expCtrl("branch_over_stall", 0, 1, 1);
    s = '0;
    applyStimulus(s, 1'b0);
    expCtrl("branch_done", 0, 0, 0);
    expCnt("cnt_after_branch", 16'd8);

    // Reset in the middle of an MDU op abandons it.
    s = '0;
    s.mdu_start_e = 1; s.rd_e = 14;
    applyStimulus(s, 1'b0);
    s = '0;
    applyStimulus(s, 1'b0);
    expMdu("mdu3_busy", 1, 0, 5'd0);
    applyStimulus(s, 1'b1);
    checkOutput("reset_mid_mdu", zero_v, all_m);
    s.rs1_d = 14;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(s, 1'b0);
      expCtrl($sformatf("post_reset_nostall%0d", i), 0, 0, 0);
      expMdu($sformatf("post_reset_idle%0d", i), 0, 0, 5'd0);
    end
    expCnt("cnt_after_reset", 16'd0);

    // Forwarding disabled: dependencies stall and forward selects stay RF.
    s = '0;
    s.reg_write_m = 1; s.rd_m = 3; s.rs1_d = 3; s.rs1_e = 3;
    applyStimulus(s, 1'b0);
    expNoFwd("nofwd_m_dep", 1, 2'b00, 2'b00);
    expFwd("fwd_m_dep", 2'b10, 2'b00);
    expCtrl("fwd_m_dep_nostall", 0, 0, 0);
    s = '0;
    s.reg_write_w = 1; s.rd_w = 4; s.rs2_d = 4; s.rs2_e = 4;
    applyStimulus(s, 1'b0);
    expNoFwd("nofwd_w_dep", 1, 2'b00, 2'b00);
    expFwd("fwd_w_dep", 2'b00, 2'b01);
    s = '0;
    s.reg_write_e = 1; s.rd_e = 6; s.rs1_d = 6;
    applyStimulus(s, 1'b0);
    expNoFwd("nofwd_e_dep", 1, 2'b00, 2'b00);
    expCtrl("fwd_e_dep_nostall", 0, 0, 0);
    s = '0;
    s.reg_write_m = 1; s.rd_m = 3; s.rs2_d = 5;
    applyStimulus(s, 1'b0);
    expNoFwd("nofwd_no_dep", 0, 2'b00, 2'b00);
    s = '0;
    s.rd_m = 3; s.rs1_d = 3;
    applyStimulus(s, 1'b0);
    expNoFwd("nofwd_we_off", 0, 2'b00, 2'b00);

    s = '0;
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);
    @(posedge clk);
    #1;

    n_total++;
    if (expq.size() == 0) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL exp_queue_drained: got %0d pending, expected 0", expq.size());
    end
    n_total++;
    if (wbq.size() == 0) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL wb_queue_drained: got %0d pending, expected 0", wbq.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_sb_unit.md
Name: hazard_sb_unit

Overview:
- Hazard unit for the 5-stage RV32 pipeline. Combines:
  - E-stage operand forwarding from M and W.
  - Load-use stall.
  - Branch flush.
  - A register scoreboard for a multi-cycle multiply/divide unit (MDU) of parametrised latency.
- Sits beside the datapath. Drives the F/D stall enables, the D/E flush enables, the E-stage forwarding muxes and the MDU write-back request.
- A saturating stall-cycle counter provides performance visibility.

Parameters:
- NREGS, 32, number of architectural registers; x0 is hard-wired zero.
- REG_W, $clog2(NREGS), register index width (derived).
- MDU_LAT, 4, cycles from MDU issue in E to result ready; legal range 1..15.
- FWD_EN, 1, 1 = forwarding on; 0 = all RAW hazards resolved by stalling.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_d, rs2_d  in  REG_W  D-stage source registers.
- rd_d  in  REG_W  D-stage destination register.
- reg_write_d  in  1  D instruction writes rd.
- mdu_op_d  in  1  D instruction is an MDU op.
- rs1_e, rs2_e, rd_e  in  REG_W  E-stage source and destination registers.
- reg_write_e  in  1  E instruction writes rd through the pipeline. Always 0 for MDU ops.
- result_src_e  in  2  E result select; 2'b01 = load.
- mdu_start_e  in  1  E holds a valid MDU op; issues this cycle.
- pcsrc_e  in  1  taken branch/jump resolved in E.
- rd_m  in  REG_W, reg_write_m  in  1  M-stage destination and write enable.
- rd_w  in  REG_W, reg_write_w  in  1  W-stage destination and write enable.
- stall_f, stall_d  out  1  hold PC and the F/D register.
- flush_d, flush_e  out  1  clear the F/D and D/E registers.
- forward_ae, forward_be  out  2  00 = register file, 01 = W result, 10 = M result.
- mdu_busy  out  1  MDU has an op in flight.
- mdu_wb_valid  out  1  MDU result writes the register file at this edge.
- mdu_wb_rd  out  REG_W  destination register for the MDU write.
- stall_cnt  out  CNT_W  saturating count of stall_d cycles.

Behaviour:
- Reset values:
  - Scoreboard busy[NREGS-1:0] = 0; cnt = 0; mdu_rd = 0; stall_cnt = 0.
  - All outputs are 0 while rst is high.
  - Reset mid-operation abandons the in-flight MDU op; no mdu_wb_valid pulse follows.
- Forwarding (combinational, applies to operand A; B is identical using rs2_e):
  - 10 if reg_write_m && rd_m==rs1_e && rs1_e!=0.
  - else 01 if reg_write_w && rd_w==rs1_e && rs1_e!=0.
  - else 00.
  - M has priority over W.
  - When FWD_EN=0, both forwarding outputs are tied to 00.
- Stall terms. A source counts only if it is nonzero.
  - lw_stall: result_src_e==2'b01 && rd_e!=0 && rd_e matches rs1_d or rs2_d.
  - sb_stall: any of the following:
    - busy[rs1_d] or busy[rs2_d];
    - busy[rd_d] && reg_write_d (WAW);
    - mdu_start_e && rd_e!=0 && rd_e matches rs1_d or rs2_d.
  - st_stall (structural): mdu_op_d && (mdu_start_e || cnt>1).
  - raw_stall (FWD_EN=0 only): a nonzero D source matches rd_e, rd_m or rd_w with the matching write enable set.
  - stall_any = (lw_stall | sb_stall | st_stall | raw_stall) & ~pcsrc_e.
- Control outputs:
  - stall_f = stall_d = stall_any.
  - flush_d = pcsrc_e.
  - flush_e = pcsrc_e | stall_any.
  - A branch overrides any stall: the D instruction is wrong-path.
- MDU scoreboard (sequential):
  - Issue: when mdu_start_e is high, at the edge set cnt = MDU_LAT, mdu_rd = rd_e, and busy[rd_e] = 1 (unless rd_e == 0).
  - Countdown: cnt decrements each cycle while cnt > 1.
  - mdu_wb_valid = (cnt==1) && !reg_write_w, combinational. W-stage writes own the single register-file port, so a colliding completion holds cnt at 1 until W is idle.
  - mdu_wb_rd = mdu_rd.
  - Completion: at an edge with mdu_wb_valid, set cnt = 0 and clear busy[mdu_rd].
  - Issue with cnt > 0 is illegal. D is prevented from issuing it by st_stall; an assertion checks it.
  - mdu_busy = (cnt != 0).
  - busy[0] is never set.
- Stall counter: stall_cnt increments on every edge where stall_d=1 and saturates at all-ones.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - RESULT_SRC_LOAD = 2'b01.
  - reg_idx_t typedef.
- Sub-module mdu_scoreboard. Holds busy bits, cnt, mdu_rd and the W-collision hold. Outputs busy vector, cnt_gt1, mdu_busy, mdu_wb_valid and mdu_wb_rd.
- Top level holds forwarding, stall/flush logic and stall_cnt.

Test Plan:
- Forward priority: rd_m = rd_w = rs1_e = 5 with reg_write_m = reg_write_w = 1 -> forward_ae = 10. Drop reg_write_m -> 01. Set rs1_e = 0 -> 00.
- Load-use: result_src_e = 01, rd_e = 7, rs2_d = 7 -> stall_f = stall_d = flush_e = 1 for exactly one cycle; stall_cnt +1.
- MDU RAW, MDU_LAT = 4: issue with rd_e = 9, then rs1_d = 9 held in D.
  - stall_d stays 1 until the edge where mdu_wb_valid = 1 and mdu_wb_rd = 9 (5 stalled cycles, including the issue cycle).
  - busy[9] = 0 afterwards.
- W collision: reg_write_w = 1 during the cycle cnt = 1 -> mdu_wb_valid = 0, cnt holds at 1. Next cycle with W idle -> write completes.
- Branch over stall: pcsrc_e = 1 while lw_stall conditions are true -> stall_d = 0, flush_d = flush_e = 1. Assert rst mid-MDU op -> busy = 0, mdu_busy = 0, and no wb pulse for 10 cycles.
- FWD_EN = 0: reg_write_m = 1, rd_m = 3, rs1_d = 3 -> stall_d = 1 and forward outputs = 00.
